// File: rtl/packet_arbiter.sv
// rtl/packet_arbiter.sv - round-robin packet arbiter that forwards one whole packet per grant
// Optional stall timeout: define PKT_ARB_TIMEOUT_EN.
module packet_arbiter #(
  parameter int NREQ    = 4,
  parameter int UWIDTH  = 8,
  parameter int TIMEOUT = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req,
  input  logic [NREQ-1:0]        in_valid,
  input  logic [NREQ*UWIDTH-1:0] in_data,
  output logic [NREQ-1:0]        gnt,
  output logic                   out_valid,
  output logic [UWIDTH-1:0]      out_data,
  output logic                   out_sop,
  output logic                   out_eop,
  output logic                   busy,
  output logic                   abort
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [2:0] {IDLE, SRC, DST, SIZE, DATA, CRC} state_t;

  state_t            state, state_n;
  logic [IW-1:0]     rr_ptr, rr_ptr_n, g_idx, g_idx_n, pick_idx, idx, nxt_ptr;
  logic              pick_found;
  logic [UWIDTH-1:0] cnt, cnt_n, in_byte, out_data_n;
  logic [NREQ-1:0]   gnt_n;
  logic              out_valid_n, out_sop_n, out_eop_n, abort_n;
  logic              accept, tmo;
  logic [UWIDTH-1:0] lane [NREQ];

  for (genvar i = 0; i < NREQ; i++) begin : g_lane
    assign lane[i] = in_data[i*UWIDTH +: UWIDTH];
  end

  assign in_byte = lane[g_idx];
  assign accept  = (state != IDLE) && in_valid[g_idx];
  assign busy    = (state != IDLE);
  assign nxt_ptr = IW'((int'(g_idx) + 1) % NREQ);

  // Scan downward so the nearest requester at or after rr_ptr is the last one written.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    idx        = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = IW'((int'(rr_ptr) + k) % NREQ);
      if (req[idx]) begin
        pick_found = 1'b1;
        pick_idx   = idx;
      end
    end
  end

`ifdef PKT_ARB_TIMEOUT_EN
  localparam int SW = $clog2(TIMEOUT + 1);
  logic [SW-1:0] stall_cnt;
  logic          stalling;

  assign stalling = (state != IDLE) && !in_valid[g_idx];
  assign tmo      = stalling && (stall_cnt == SW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst || !stalling || (state_n != state))
      stall_cnt <= '0;
    else
      stall_cnt <= stall_cnt + SW'(1);
  end
`else
  assign tmo = 1'b0;
`endif

  always_comb begin
    state_n     = state;
    rr_ptr_n    = rr_ptr;
    g_idx_n     = g_idx;
    cnt_n       = cnt;
    gnt_n       = gnt;
    out_valid_n = accept;
    out_data_n  = accept ? in_byte : out_data;
    out_sop_n   = accept && (state == SRC);
    out_eop_n   = 1'b0;
    abort_n     = 1'b0;
    case (state)
      IDLE: if (pick_found) begin
        g_idx_n = pick_idx;
        gnt_n   = NREQ'(1) << pick_idx;
        state_n = SRC;
      end
      SRC:  if (accept) state_n = DST;
      DST:  if (accept) state_n = SIZE;
      SIZE: if (accept) begin
        cnt_n   = in_byte;
        state_n = (in_byte == '0) ? CRC : DATA;
      end
      DATA: if (accept) begin
        cnt_n = cnt - UWIDTH'(1);
        if (cnt == UWIDTH'(1)) state_n = CRC;
      end
      CRC: if (accept) begin
        out_eop_n = 1'b1;
        gnt_n     = '0;
        rr_ptr_n  = nxt_ptr;
        state_n   = IDLE;
      end
      default: state_n = IDLE;
    endcase
    // An abort ends the packet without a data byte and skips the stalled source.
    if (tmo) begin
      out_valid_n = 1'b0;
      out_sop_n   = 1'b0;
      out_eop_n   = 1'b1;
      abort_n     = 1'b1;
      gnt_n       = '0;
      rr_ptr_n    = nxt_ptr;
      state_n     = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      g_idx     <= '0;
      cnt       <= '0;
      gnt       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sop   <= 1'b0;
      out_eop   <= 1'b0;
      abort     <= 1'b0;
    end else begin
      state     <= state_n;
      rr_ptr    <= rr_ptr_n;
      g_idx     <= g_idx_n;
      cnt       <= cnt_n;
      gnt       <= gnt_n;
      out_valid <= out_valid_n;
      out_data  <= out_data_n;
      out_sop   <= out_sop_n;
      out_eop   <= out_eop_n;
      abort     <= abort_n;
    end
  end

endmodule

// File: tb/tb_packet_arbiter.sv
// tb/tb_packet_arbiter.sv - directed self-checking bench for packet_arbiter
module tb_packet_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [3:0]  in_valid;
  logic [31:0] in_data;
  logic [3:0]  gnt;
  logic        out_valid;
  logic [7:0]  out_data;
  logic        out_sop, out_eop, busy, abort;

  int vecs = 0;
  int errs = 0;

  packet_arbiter #(.NREQ(4), .UWIDTH(8), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .req(req), .in_valid(in_valid), .in_data(in_data),
    .gnt(gnt), .out_valid(out_valid), .out_data(out_data), .out_sop(out_sop),
    .out_eop(out_eop), .busy(busy), .abort(abort)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_gnt"}, gnt, 0);
    chk({tag, "_valid"}, out_valid, 0);
    chk({tag, "_data"}, out_data, 0);
    chk({tag, "_sop"}, out_sop, 0);
    chk({tag, "_eop"}, out_eop, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_abort"}, abort, 0);
  endtask

  // Every lane strobes junk; only the granted lane carries the real byte.
  task automatic send_one(input int r, input logic [7:0] b, input logic sop, input logic eop);
    in_valid = 4'hF;
    in_data  = {4{8'hEE}};
    in_data[r*8 +: 8] = b;
    tick;
    in_valid = 4'h0;
    chk("out_valid", out_valid, 1);
    chk("out_data", out_data, b);
    chk("out_sop", out_sop, sop);
    chk("out_eop", out_eop, eop);
    chk("gnt_hold", gnt, eop ? 0 : (1 << r));
    chk("busy", busy, !eop);
  endtask

  task automatic gap(input int r);
    in_valid = ~(4'b0001 << r);
    in_data  = {4{8'hEE}};
    tick;
    in_valid = 4'h0;
    chk("gap_valid", out_valid, 0);
    chk("gap_gnt", gnt, 1 << r);
    chk("gap_abort", abort, 0);
  endtask

  initial begin
    rst = 1'b1; req = 4'hF; in_valid = 4'hF; in_data = 32'hDEADBEEF;
    tick; tick;
    chk_idle_outputs("reset");
    rst = 1'b0; req = 4'h0; in_valid = 4'h0;
    tick;
    chk("idle_gnt", gnt, 0);

    // Single packet from requester 0
    req = 4'b0001;
    tick;
    chk("single_gnt", gnt, 4'b0001);
    chk("single_busy", busy, 1);
    req = 4'h0;
    send_one(0, 8'd10, 1, 0);
    send_one(0, 8'd160, 0, 0);
    send_one(0, 8'd3, 0, 0);
    send_one(0, 8'd0, 0, 0);
    send_one(0, 8'd1, 0, 0);
    send_one(0, 8'd2, 0, 0);
    send_one(0, 8'd15, 0, 1);
    tick;
    chk("single_after_valid", out_valid, 0);
    chk("single_after_eop", out_eop, 0);

    // Size-0 packet from requester 2
    req = 4'b0100;
    tick;
    chk("size0_gnt", gnt, 4'b0100);
    req = 4'h0;
    send_one(2, 8'd100, 1, 0);
    send_one(2, 8'd10, 0, 0);
    send_one(2, 8'd0, 0, 0);
    send_one(2, 8'd55, 0, 1);

    // Round robin from a fresh pointer
    rst = 1'b1;
    tick;
    rst = 1'b0;
    req = 4'hF;
    tick;
    for (int k = 0; k < 5; k++) begin
      chk("rr_gnt", gnt, 1 << (k % 4));
      send_one(k % 4, 8'(k % 4), 1, 0);
      send_one(k % 4, 8'd9, 0, 0);
      send_one(k % 4, 8'd1, 0, 0);
      send_one(k % 4, 8'h40 + 8'(k), 0, 0);
      if (k == 4) req = 4'h0;
      send_one(k % 4, 8'hC0 + 8'(k), 0, 1);
      tick;
    end
    chk("rr_end_gnt", gnt, 0);

    // Requester 1 with gaps and req dropped in DATA (pointer now 1)
    req = 4'b0010;
    tick;
    chk("gap_grant", gnt, 4'b0010);
    send_one(1, 8'd1, 1, 0);
    send_one(1, 8'd2, 0, 0);
    send_one(1, 8'd3, 0, 0);
    send_one(1, 8'd7, 0, 0);
    req = 4'h0;
    gap(1); gap(1); gap(1);
    send_one(1, 8'd8, 0, 0);
    send_one(1, 8'd9, 0, 0);
    send_one(1, 8'hAA, 0, 1);

    // Reset in the middle of a size-4 packet (pointer now 2)
    req = 4'b0100;
    tick;
    chk("mid_gnt", gnt, 4'b0100);
    req = 4'h0;
    send_one(2, 8'd5, 1, 0);
    send_one(2, 8'd6, 0, 0);
    send_one(2, 8'd4, 0, 0);
    send_one(2, 8'd1, 0, 0);
    rst = 1'b1;
    tick;
    chk_idle_outputs("midrst");
    rst = 1'b0;
    req = 4'b1010;
    tick;
    chk("post_rst_gnt", gnt, 4'b0010);
    req = 4'h0;
    send_one(1, 8'd1, 1, 0);
    send_one(1, 8'd0, 0, 0);
    send_one(1, 8'd0, 0, 0);
    send_one(1, 8'h33, 0, 1);

    // Requester 3 stalls after dest_id (pointer now 2)
    req = 4'b1001;
    tick;
    chk("stall_gnt", gnt, 4'b1000);
    send_one(3, 8'd3, 1, 0);
    send_one(3, 8'd4, 0, 0);
    for (int s = 0; s < 15; s++) tick;
    chk("stall_abort_early", abort, 0);
    chk("stall_busy", busy, 1);
    tick;
`ifdef PKT_ARB_TIMEOUT_EN
    chk("tmo_abort", abort, 1);
    chk("tmo_eop", out_eop, 1);
    chk("tmo_valid", out_valid, 0);
    chk("tmo_gnt", gnt, 0);
    tick;
    chk("tmo_abort_pulse", abort, 0);
    chk("tmo_next_gnt", gnt, 4'b0001);
`else
    chk("no_tmo_abort", abort, 0);
    chk("no_tmo_gnt", gnt, 4'b1000);
    chk("no_tmo_eop", out_eop, 0);
`endif
    req = 4'h0;
    rst = 1'b1;
    tick;
    chk_idle_outputs("final");

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
